ula_issue: RTL and testbench
============================

// Module: ula_issue
// PURPOSE
//  Issue stage directly upstream of the ULA. Accepts a decoded instruction bundle
//  (opcode/funct fields plus register and immediate values) over valid/ready.
//  Maps it to the ULA op code and sign, and selects operand b.
//  Holds the result in a 2-entry skid buffer whose outputs drive ula a/b/op/sign.
//  Also flags branch-compare inversion and illegal encodings.
// PARAMETERS
//  BITS  63  MSB index of the datapath; operands are [BITS:0], as in ula.
// PORTS
//  clock        in   1       sole clock; all state on rising edge
//  reset        in   1       asynchronous, active-high; clears all state
//  flush        in   1       synchronous pipeline flush
//  in_valid     in   1       upstream bundle valid
//  in_ready     out  1       stage can accept (registered: !skid_full)
//  instr        in   32      RISC-V instruction; uses [6:0],[14:12],[30]
//  rs1_val      in   BITS+1  register operand 1
//  rs2_val      in   BITS+1  register operand 2
//  imm          in   BITS+1  sign-extended immediate
//  out_valid    out  1       bundle presented to ULA
//  out_ready    in   1       downstream (EX) accepts
//  out_a        out  BITS+1  -> ula.a (always rs1_val)
//  out_b        out  BITS+1  -> ula.b (rs2_val for OP/BRANCH, imm otherwise)
//  out_op       out  4       -> ula.op
//  out_sign     out  1       -> ula.sign
//  out_inv      out  1       branch taken = !ula.result[0] (BGE/BGEU)
//  out_illegal  out  1       unsupported encoding; op forced to ADD (0001)
// BEHAVIOUR
//  ULA op codes: SUB 0000, ADD 0001, EQU 0010, SLT 0011, SLL 0100, XOR 0101,
//   OR 0110, AND 0111, SRL 1000, SRA 1001, SGT 1010, NEQ 1011.
//  Decode (sign=1 unless stated; inv=0 unless stated):
//   OP 0110011 / OP-IMM 0010011, funct3:
//    000 ADD; OP with instr[30]=1 -> SUB
//    001 SLL; 010 SLT; 011 SLT sign=0; 100 XOR
//    101 SRL, or SRA if instr[30]=1; 110 OR; 111 AND
//   BRANCH 1100011, funct3:
//    000 EQU; 001 NEQ; 100 SLT; 101 SLT inv=1
//    110 SLT sign=0; 111 SLT sign=0 inv=1; 010/011 illegal
//   LOAD 0000011 / STORE 0100011: ADD, b=imm
//   any other opcode: illegal, op=ADD, b=imm
//  Decode is combinational on the input; result is captured at accept.
//  Accept = in_valid & in_ready. Issue = out_valid & out_ready.
//  Skid FSM, 3 states:
//   EMPTY -> ONE on accept.
//   ONE: accept & !issue -> FULL. accept & issue -> ONE (main reloads).
//        !accept & issue -> EMPTY. Otherwise stay.
//   FULL: issue -> ONE (skid moves to main); in_ready=0, so no accept in FULL.
//  Latency: accept to out_valid = 1 cycle. Throughput: 1 bundle/cycle.
//  Order is strictly FIFO. Output fields are stable while out_valid & !out_ready.
//  flush: next edge -> EMPTY, out_valid=0, in_ready=1.
//   Overrides any simultaneous accept or issue; that input is dropped.
//  Reset values: out_valid=0, in_ready=1, every data/flag output 0, FSM EMPTY.
//  Reset mid-transfer drops all held bundles. No partial state survives.
//  Output data while out_valid=0 is don't-care; the bench must not check it.
// CONFIGURATION
//  ULA_ISSUE_PERF_EN defined: adds two outputs.
//   cnt_issued [31:0]: +1 per issue.
//   cnt_stall [31:0]: +1 per cycle with out_valid & !out_ready.
//   Both wrap at 2^32, clear on reset only (not on flush).
//  Undefined: ports and counters are absent; all other behaviour is identical.
// TESTING
//  1. Reset mid-stream -> out_valid=0, in_ready=1 asynchronously; all outputs 0.
//  2. ADD (instr=0x00208033), then SUB (0x40208033), out_ready=1
//     -> out_op 0001 then 0000, each 1 cycle after its accept.
//  3. BGEU (funct3=111), rs1=1, rs2=2
//     -> op=0011, sign=0, inv=1, out_b=2.
//  4. out_ready=0 with 3 bundles offered -> 2 accepted, in_ready=0.
//     Then out_ready=1 -> the 2 bundles issue in order.
//  5. flush asserted while FULL and in_valid=1 -> next cycle EMPTY, in_ready=1,
//     nothing issued. Opcode 0x7F -> illegal=1, op=0001.
//  6. ULA_ISSUE_PERF_EN: 4 issues and 3 stall cycles -> cnt_issued=4, cnt_stall=3.

Source files
------------

// File: rtl/ula_issue.sv
// Issue stage feeding the ULA: decodes the bundle, selects operand b, and holds
// results in a 2-entry skid buffer. Optional counters under ULA_ISSUE_PERF_EN.
module ula_issue #(
  parameter int BITS = 63
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [31:0]   instr,
  input  logic [BITS:0] rs1_val,
  input  logic [BITS:0] rs2_val,
  input  logic [BITS:0] imm,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [BITS:0] out_a,
  output logic [BITS:0] out_b,
  output logic [3:0]    out_op,
  output logic          out_sign,
  output logic          out_inv,
  output logic          out_illegal
`ifdef ULA_ISSUE_PERF_EN
  ,
  output logic [31:0]   cnt_issued,
  output logic [31:0]   cnt_stall
`endif
);

  localparam logic [3:0] OP_SUB = 4'b0000, OP_ADD = 4'b0001, OP_EQU = 4'b0010,
                         OP_SLT = 4'b0011, OP_SLL = 4'b0100, OP_XOR = 4'b0101,
                         OP_OR  = 4'b0110, OP_AND = 4'b0111, OP_SRL = 4'b1000,
                         OP_SRA = 4'b1001, OP_NEQ = 4'b1011;

  localparam logic [6:0] OPC_OP = 7'b0110011, OPC_IMM = 7'b0010011,
                         OPC_BR = 7'b1100011, OPC_LD  = 7'b0000011,
                         OPC_ST = 7'b0100011;

  typedef struct packed {
    logic [BITS:0] a;
    logic [BITS:0] b;
    logic [3:0]    op;
    logic          sign;
    logic          inv;
    logic          illegal;
  } bundle_t;

  typedef enum logic [1:0] {EMPTY = 2'b00, ONE = 2'b01, FULL = 2'b10} state_t;

  state_t  state_r, state_next_s;
  bundle_t dec_s, main_r, skid_r;
  logic    accept_s, issue_s;
  logic    load_main_in_s, load_main_skid_s, load_skid_s;
  logic    unused_bits;

  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  assign accept_s = in_valid & in_ready;
  assign issue_s  = out_valid & out_ready;

  // Combinational decode of the offered bundle into ULA controls.
  always_comb begin
    dec_s.a       = rs1_val;
    dec_s.b       = imm;
    dec_s.op      = OP_ADD;
    dec_s.sign    = 1'b1;
    dec_s.inv     = 1'b0;
    dec_s.illegal = 1'b0;
    case (instr[6:0])
      OPC_OP, OPC_IMM: begin
        if (instr[6:0] == OPC_OP) dec_s.b = rs2_val;
        else                      dec_s.b = imm;
        case (instr[14:12])
          3'b000: begin
            if ((instr[6:0] == OPC_OP) && instr[30]) dec_s.op = OP_SUB;
            else                                    dec_s.op = OP_ADD;
          end
          3'b001: dec_s.op = OP_SLL;
          3'b010: dec_s.op = OP_SLT;
          3'b011: begin dec_s.op = OP_SLT; dec_s.sign = 1'b0; end
          3'b100: dec_s.op = OP_XOR;
          3'b101: begin
            if (instr[30]) dec_s.op = OP_SRA;
            else           dec_s.op = OP_SRL;
          end
          3'b110: dec_s.op = OP_OR;
          3'b111: dec_s.op = OP_AND;
          default: dec_s.op = OP_ADD;
        endcase
      end
      OPC_BR: begin
        dec_s.b = rs2_val;
        case (instr[14:12])
          3'b000: dec_s.op = OP_EQU;
          3'b001: dec_s.op = OP_NEQ;
          3'b100: dec_s.op = OP_SLT;
          3'b101: begin dec_s.op = OP_SLT; dec_s.inv = 1'b1; end
          3'b110: begin dec_s.op = OP_SLT; dec_s.sign = 1'b0; end
          3'b111: begin dec_s.op = OP_SLT; dec_s.sign = 1'b0; dec_s.inv = 1'b1; end
          default: begin dec_s.op = OP_ADD; dec_s.illegal = 1'b1; end
        endcase
      end
      OPC_LD, OPC_ST: dec_s.op = OP_ADD;
      default: dec_s.illegal = 1'b1;
    endcase
  end

  // Skid FSM next state and register load strobes; flush wins over everything.
  always_comb begin
    state_next_s     = state_r;
    load_main_in_s   = 1'b0;
    load_main_skid_s = 1'b0;
    load_skid_s      = 1'b0;
    if (flush) begin
      state_next_s = EMPTY;
    end else begin
      case (state_r)
        EMPTY: begin
          if (accept_s) begin
            state_next_s   = ONE;
            load_main_in_s = 1'b1;
          end else begin
            state_next_s = EMPTY;
          end
        end
        ONE: begin
          if (accept_s && !issue_s) begin
            state_next_s = FULL;
            load_skid_s  = 1'b1;
          end else if (accept_s && issue_s) begin
            state_next_s   = ONE;
            load_main_in_s = 1'b1;
          end else if (issue_s) begin
            state_next_s = EMPTY;
          end else begin
            state_next_s = ONE;
          end
        end
        FULL: begin
          if (issue_s) begin
            state_next_s     = ONE;
            load_main_skid_s = 1'b1;
          end else begin
            state_next_s = FULL;
          end
        end
        default: state_next_s = EMPTY;
      endcase
    end
  end

  // State register with handshake outputs registered from the next state.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_r   <= EMPTY;
      out_valid <= 1'b0;
      in_ready  <= 1'b1;
    end else begin
      state_r   <= state_next_s;
      out_valid <= (state_next_s != EMPTY);
      in_ready  <= (state_next_s != FULL);
    end
  end

  // Main (presented) and skid data registers.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      main_r <= '0;
      skid_r <= '0;
    end else begin
      if (load_main_in_s)        main_r <= dec_s;
      else if (load_main_skid_s) main_r <= skid_r;
      else                       main_r <= main_r;
      if (load_skid_s) skid_r <= dec_s;
      else             skid_r <= skid_r;
    end
  end

  assign out_a       = main_r.a;
  assign out_b       = main_r.b;
  assign out_op      = main_r.op;
  assign out_sign    = main_r.sign;
  assign out_inv     = main_r.inv;
  assign out_illegal = main_r.illegal;

`ifdef ULA_ISSUE_PERF_EN
  // Issue and stall counters survive flush; a flushed issue is not counted.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cnt_issued <= 32'd0;
      cnt_stall  <= 32'd0;
    end else begin
      if (issue_s && !flush) cnt_issued <= cnt_issued + 32'd1;
      else                   cnt_issued <= cnt_issued;
      if (out_valid && !out_ready) cnt_stall <= cnt_stall + 32'd1;
      else                         cnt_stall <= cnt_stall;
    end
  end
`endif

endmodule

// File: tb/tb_ula_issue.sv
// Bench for ula_issue: FIFO-queue reference model checked every cycle, plus
// literal expectations for the directed scenarios.
module tb_ula_issue;
  logic        clock = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] instr;
  logic [63:0] rs1_val, rs2_val, imm, out_a, out_b;
  logic [3:0]  out_op;
  logic        out_sign, out_inv, out_illegal;
`ifdef ULA_ISSUE_PERF_EN
  logic [31:0] cnt_issued, cnt_stall;
`endif

  int total = 0;
  int bad = 0;
  int m_iss = 0;
  int m_stall = 0;

  typedef struct {
    logic [63:0] a, b;
    logic [3:0]  op;
    logic        sign, inv, ill;
  } bun_t;
  bun_t q[$];

  ula_issue #(.BITS(63)) dut (
    .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid),
    .in_ready(in_ready), .instr(instr), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a),
    .out_b(out_b), .out_op(out_op), .out_sign(out_sign), .out_inv(out_inv),
    .out_illegal(out_illegal)
`ifdef ULA_ISSUE_PERF_EN
    , .cnt_issued(cnt_issued), .cnt_stall(cnt_stall)
`endif
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bun_t model_dec(input logic [31:0] ins, input logic [63:0] r1,
                                     input logic [63:0] r2, input logic [63:0] im);
    bun_t r;
    logic [3:0] alu_tab [0:7];
    logic [6:0] opc;
    logic [2:0] f;
    alu_tab = '{4'd1, 4'd4, 4'd3, 4'd3, 4'd5, 4'd8, 4'd6, 4'd7};
    opc = ins[6:0];
    f = ins[14:12];
    r.a = r1; r.b = im; r.op = 4'd1; r.sign = 1'b1; r.inv = 1'b0; r.ill = 1'b0;
    if (opc == 7'h33 || opc == 7'h13) begin
      if (opc == 7'h33) r.b = r2;
      r.op = alu_tab[f];
      if (f == 3'd3) r.sign = 1'b0;
      if (ins[30] && f == 3'd5) r.op = 4'd9;
      if (ins[30] && f == 3'd0 && opc == 7'h33) r.op = 4'd0;
    end else if (opc == 7'h63) begin
      r.b = r2;
      if (f == 3'd0) r.op = 4'd2;
      else if (f == 3'd1) r.op = 4'd11;
      else if (f[2]) begin r.op = 4'd3; r.sign = ~f[1]; r.inv = f[0]; end
      else r.ill = 1'b1;
    end else if (opc != 7'h03 && opc != 7'h23) begin
      r.ill = 1'b1;
    end
    return r;
  endfunction

  task automatic model_update();
    int n;
    n = q.size();
    if (reset) begin
      q.delete(); m_iss = 0; m_stall = 0;
    end else begin
      if (n > 0 && !out_ready) m_stall++;
      if (flush) q.delete();
      else begin
        if (n > 0 && out_ready) begin void'(q.pop_front()); m_iss++; end
        if (in_valid && n < 2) q.push_back(model_dec(instr, rs1_val, rs2_val, imm));
      end
    end
  endtask

  task automatic compare();
    check("out_valid", {63'd0, out_valid}, {63'd0, q.size() > 0});
    check("in_ready", {63'd0, in_ready}, {63'd0, q.size() < 2});
    if (q.size() > 0) begin
      check("out_a", out_a, q[0].a);
      check("out_b", out_b, q[0].b);
      check("out_op", {60'd0, out_op}, {60'd0, q[0].op});
      check("out_sign", {63'd0, out_sign}, {63'd0, q[0].sign});
      check("out_inv", {63'd0, out_inv}, {63'd0, q[0].inv});
      check("out_illegal", {63'd0, out_illegal}, {63'd0, q[0].ill});
    end
`ifdef ULA_ISSUE_PERF_EN
    check("cnt_issued", {32'd0, cnt_issued}, m_iss);
    check("cnt_stall", {32'd0, cnt_stall}, m_stall);
`endif
  endtask

  task automatic step();
    @(posedge clock);
    model_update();
    @(negedge clock);
    compare();
  endtask

  task automatic offer(input logic [31:0] ins, input logic [63:0] r1, input logic [63:0] r2);
    in_valid = 1'b1; instr = ins; rs1_val = r1; rs2_val = r2; imm = 64'h10;
  endtask

  initial begin
    logic [6:0]  opcs [0:5];
    logic [31:0] r;
    opcs = '{7'h33, 7'h13, 7'h63, 7'h03, 7'h23, 7'h7F};
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0; rs1_val = 64'd0; rs2_val = 64'd0; imm = 64'd0;
    step(); step();
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    reset = 1'b0;

    // Counter scenario: 1 accept, 3 stall cycles, 4 issues.
    offer(32'h00208033, 64'd1, 64'd1); out_ready = 1'b0; step();
    in_valid = 1'b0; step(); step(); step();
    offer(32'h00208033, 64'd2, 64'd1); out_ready = 1'b1; step(); step(); step();
    in_valid = 1'b0; step();
`ifdef ULA_ISSUE_PERF_EN
    check("perf_issued_lit", {32'd0, cnt_issued}, 64'd4);
    check("perf_stall_lit", {32'd0, cnt_stall}, 64'd3);
`endif

    // ADD then SUB back to back.
    offer(32'h00208033, 64'd5, 64'd7); step();
    check("add_op_lit", {60'd0, out_op}, 64'd1);
    check("add_valid_lit", {63'd0, out_valid}, 64'd1);
    offer(32'h40208033, 64'd9, 64'd4); step();
    check("sub_op_lit", {60'd0, out_op}, 64'd0);
    in_valid = 1'b0; step();

    // BGEU.
    offer(32'h00007063, 64'd1, 64'd2); step();
    in_valid = 1'b0;
    check("bgeu_op_lit", {60'd0, out_op}, 64'd3);
    check("bgeu_sign_lit", {63'd0, out_sign}, 64'd0);
    check("bgeu_inv_lit", {63'd0, out_inv}, 64'd1);
    check("bgeu_b_lit", out_b, 64'd2);
    step();

    // Backpressure: 3 offered, 2 accepted, then drain in order.
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      offer(32'h00208033, 64'd10 + 64'(k), 64'd0); step();
    end
    check("bp_in_ready_lit", {63'd0, in_ready}, 64'd0);
    check("bp_first_lit", out_a, 64'd10);
    in_valid = 1'b0; out_ready = 1'b1; step();
    check("bp_second_lit", out_a, 64'd11);
    step();
    check("bp_drained_lit", {63'd0, out_valid}, 64'd0);

    // Flush while FULL with a bundle offered, then an illegal opcode.
    out_ready = 1'b0;
    offer(32'h00208033, 64'd20, 64'd0); step(); step();
    check("fl_full_lit", {63'd0, in_ready}, 64'd0);
    flush = 1'b1; step();
    flush = 1'b0;
    check("fl_valid_lit", {63'd0, out_valid}, 64'd0);
    check("fl_ready_lit", {63'd0, in_ready}, 64'd1);
    offer(32'h0000007F, 64'd3, 64'd0); out_ready = 1'b1; step();
    check("ill_flag_lit", {63'd0, out_illegal}, 64'd1);
    check("ill_op_lit", {60'd0, out_op}, 64'd1);
    in_valid = 1'b0; step();

    // Asynchronous reset mid-stream.
    out_ready = 1'b0;
    offer(32'h00001013, 64'hDEAD, 64'hBEEF); step(); step();
    #2 reset = 1'b1;
    #1;
    check("arst_valid", {63'd0, out_valid}, 64'd0);
    check("arst_ready", {63'd0, in_ready}, 64'd1);
    check("arst_a", out_a, 64'd0);
    check("arst_b", out_b, 64'd0);
    check("arst_flags", {57'd0, out_op, out_sign, out_inv, out_illegal}, 64'd0);
    q.delete(); m_iss = 0; m_stall = 0;
    in_valid = 1'b0;
    step();
    reset = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      r = $urandom();
      instr = {r[31:7], opcs[$urandom_range(0, 5)]};
      if (r[3:0] == 4'd0) instr[6:0] = r[26:20];
      rs1_val = {$urandom(), $urandom()};
      rs2_val = {$urandom(), $urandom()};
      imm = {$urandom(), $urandom()};
      in_valid = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      step();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
